// File: rtl/chase_pkg.sv
// -----------------------------------------------------------------------------
// chase_pkg
// Shared definitions for the chase configuration controller:
//   - DEBOUNCE_WIDTH_DEFAULT : default debounce counter width
//   - field_e                : encoding of the editable field (SPEED/TAIL/DIR/INV)
//   - next_field()           : successor of a field in the selection ring
// -----------------------------------------------------------------------------
package chase_pkg;

    localparam int DEBOUNCE_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        FIELD_SPEED = 2'd0,
        FIELD_TAIL  = 2'd1,
        FIELD_DIR   = 2'd2,
        FIELD_INV   = 2'd3
    } field_e;

    // Selection ring: SPEED -> TAIL -> DIR -> INV -> SPEED.
    function automatic field_e next_field(input field_e cur);
        field_e nxt;
        case (cur)
            FIELD_SPEED: nxt = FIELD_TAIL;
            FIELD_TAIL:  nxt = FIELD_DIR;
            FIELD_DIR:   nxt = FIELD_INV;
            FIELD_INV:   nxt = FIELD_SPEED;
            default:     nxt = FIELD_SPEED;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchronizer followed by a counter-based debounce filter for one
// raw pushbutton. The debounced level only changes after the synchronized
// level has disagreed with it on 2^WIDTH consecutive edges; press_o is a
// combinational one-cycle pulse in the cycle after the debounced level rises.
//
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   btn_i   : raw button, asynchronous to clk, active-high
//   press_o : one-cycle pulse on debounced 0->1 transition
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int WIDTH = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic             deb_prev_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    // Filter: count consecutive disagreements; accept the new level only
    // when the counter is saturated and the disagreement is still present.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Debounce state registers; deb_prev_q delays the level for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    // Rising edge of the debounced level; releases produce nothing.
    assign press_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/chase_config_ctrl.sv
// -----------------------------------------------------------------------------
// chase_config_ctrl
// Two-button configuration editor for an LED chaser. btn_sel walks through the
// editable fields (SPEED, TAIL, DIR, INV); btn_inc edits the selected field
// (SPEED increments modulo 8, the others toggle). All outputs are registered.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   btn_sel     : raw select button (async, active-high)
//   btn_inc     : raw edit button (async, active-high)
//   cfg_speed   : chase speed prefix (3 bits)
//   cfg_tail    : fade tail enable
//   cfg_dir     : chase direction, 1 = forward
//   cfg_invert  : LED polarity invert
//   field       : currently selected field (chase_pkg::field_e encoding)
//   cfg_changed : one-cycle pulse in the cycle a cfg_* output took a new value
// -----------------------------------------------------------------------------
module chase_config_ctrl
    import chase_pkg::*;
#(
    parameter int         DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEFAULT,
    parameter logic [2:0] SPEED_RESET    = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic [2:0] cfg_speed,
    output logic       cfg_tail,
    output logic       cfg_dir,
    output logic       cfg_invert,
    output logic [1:0] field,
    output logic       cfg_changed
);

    logic       sel_press_s;
    logic       inc_press_s;

    field_e     state_q;
    field_e     state_d;

    logic       inc_speed_s;
    logic       tog_tail_s;
    logic       tog_dir_s;
    logic       tog_inv_s;

    logic [2:0] speed_q;
    logic [2:0] speed_d;
    logic       tail_q;
    logic       tail_d;
    logic       dir_q;
    logic       dir_d;
    logic       inv_q;
    logic       inv_d;
    logic       changed_q;
    logic       changed_d;

    button_debounce #(
        .WIDTH (DEBOUNCE_WIDTH)
    ) u_deb_sel (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_sel),
        .press_o (sel_press_s)
    );

    button_debounce #(
        .WIDTH (DEBOUNCE_WIDTH)
    ) u_deb_inc (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn_inc),
        .press_o (inc_press_s)
    );

    // Field-selection state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FIELD_SPEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next field: advance one step per select press.
    always_comb begin
        state_d = state_q;
        if (sel_press_s) begin
            state_d = next_field(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // Edit decode: an inc press acts on the field held before this edge, so a
    // simultaneous select press edits the old field and then moves on.
    always_comb begin
        inc_speed_s = 1'b0;
        tog_tail_s  = 1'b0;
        tog_dir_s   = 1'b0;
        tog_inv_s   = 1'b0;
        if (inc_press_s) begin
            case (state_q)
                FIELD_SPEED: inc_speed_s = 1'b1;
                FIELD_TAIL:  tog_tail_s  = 1'b1;
                FIELD_DIR:   tog_dir_s   = 1'b1;
                FIELD_INV:   tog_inv_s   = 1'b1;
                default:     inc_speed_s = 1'b0;
            endcase
        end else begin
            inc_speed_s = 1'b0;
        end
    end

    // Next configuration values; every inc press changes exactly one field.
    always_comb begin
        speed_d   = speed_q;
        tail_d    = tail_q;
        dir_d     = dir_q;
        inv_d     = inv_q;
        changed_d = inc_press_s;
        if (inc_speed_s) begin
            speed_d = speed_q + 3'd1;
        end else begin
            speed_d = speed_q;
        end
        if (tog_tail_s) begin
            tail_d = ~tail_q;
        end else begin
            tail_d = tail_q;
        end
        if (tog_dir_s) begin
            dir_d = ~dir_q;
        end else begin
            dir_d = dir_q;
        end
        if (tog_inv_s) begin
            inv_d = ~inv_q;
        end else begin
            inv_d = inv_q;
        end
    end

    // Configuration and change-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_q   <= SPEED_RESET;
            tail_q    <= 1'b0;
            dir_q     <= 1'b1;
            inv_q     <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            speed_q   <= speed_d;
            tail_q    <= tail_d;
            dir_q     <= dir_d;
            inv_q     <= inv_d;
            changed_q <= changed_d;
        end
    end

    assign cfg_speed   = speed_q;
    assign cfg_tail    = tail_q;
    assign cfg_dir     = dir_q;
    assign cfg_invert  = inv_q;
    assign field       = state_q;
    assign cfg_changed = changed_q;

endmodule

// File: tb/tb_chase_config_ctrl.sv
module tb_chase_config_ctrl;
    import chase_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_sel;
    logic       btn_inc;
    logic [2:0] cfg_speed;
    logic       cfg_tail;
    logic       cfg_dir;
    logic       cfg_invert;
    logic [1:0] field;
    logic       cfg_changed;

    chase_config_ctrl #(
        .DEBOUNCE_WIDTH (3),
        .SPEED_RESET    (3'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_sel     (btn_sel),
        .btn_inc     (btn_inc),
        .cfg_speed   (cfg_speed),
        .cfg_tail    (cfg_tail),
        .cfg_dir     (cfg_dir),
        .cfg_invert  (cfg_invert),
        .field       (field),
        .cfg_changed (cfg_changed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] speed;
        logic       tail;
        logic       dir;
        logic       inv;
        logic [1:0] fld;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model of the configuration state
    logic [2:0] m_speed;
    logic       m_tail;
    logic       m_dir;
    logic       m_inv;
    logic [1:0] m_field;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_speed = 3'd0;
        m_tail  = 1'b0;
        m_dir   = 1'b1;
        m_inv   = 1'b0;
        m_field = 2'd0;
    endtask

    task automatic push_exp();
        sb_q.push_back({m_speed, m_tail, m_dir, m_inv, m_field});
    endtask

    task automatic check_all(input string tag);
        check({tag, "_speed"},   {29'd0, cfg_speed}, {29'd0, m_speed});
        check({tag, "_tail"},    {31'd0, cfg_tail},  {31'd0, m_tail});
        check({tag, "_dir"},     {31'd0, cfg_dir},   {31'd0, m_dir});
        check({tag, "_invert"},  {31'd0, cfg_invert}, {31'd0, m_inv});
        check({tag, "_field"},   {30'd0, field},     {30'd0, m_field});
        check({tag, "_changed"}, {31'd0, cfg_changed}, 32'd0);
    endtask

    // Hold the selected buttons for 'hold' cycles, release, let release settle.
    task automatic press(input bit sel, input bit inc, input int hold);
        @(negedge clk);
        if (sel) btn_sel = 1'b1;
        if (inc) btn_inc = 1'b1;
        repeat (hold) @(negedge clk);
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    // Monitor: every cfg_changed pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && cfg_changed === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_cfg_changed", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_speed",  {29'd0, cfg_speed},  {29'd0, mon_e.speed});
                check("sb_tail",   {31'd0, cfg_tail},   {31'd0, mon_e.tail});
                check("sb_dir",    {31'd0, cfg_dir},    {31'd0, mon_e.dir});
                check("sb_invert", {31'd0, cfg_invert}, {31'd0, mon_e.inv});
                check("sb_field",  {30'd0, field},      {30'd0, mon_e.fld});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all("reset");

        // First inc press: exact edge timing (new value on edge 11)
        @(negedge clk);
        btn_inc = 1'b1;
        m_speed = 3'd1;
        push_exp();
        repeat (10) @(posedge clk);
        #1;
        check("edge10_speed",   {29'd0, cfg_speed},   32'd0);
        check("edge10_changed", {31'd0, cfg_changed}, 32'd0);
        @(posedge clk);
        #1;
        check("edge11_speed",   {29'd0, cfg_speed},   32'd1);
        check("edge11_changed", {31'd0, cfg_changed}, 32'd1);
        @(posedge clk);
        #1;
        check("edge12_changed", {31'd0, cfg_changed}, 32'd0);
        repeat (8) @(negedge clk);
        btn_inc = 1'b0;
        repeat (16) @(negedge clk);
        check_all("inc1");

        // Seven more presses: 2..7 then wrap to 0
        for (int i = 2; i <= 8; i++) begin
            m_speed = m_speed + 3'd1;
            push_exp();
            press(1'b0, 1'b1, 20);
        end
        check_all("speed_wrap");

        // Bounce shorter than the filter: nothing changes
        press(1'b0, 1'b1, 5);
        check_all("bounce");

        // Select three times -> INV
        for (int i = 1; i <= 3; i++) begin
            m_field = m_field + 2'd1;
            press(1'b1, 1'b0, 20);
            check("sel_field", {30'd0, field}, {30'd0, m_field});
        end
        m_inv = 1'b1;
        push_exp();
        press(1'b0, 1'b1, 20);
        check_all("inv_toggle");

        // Fourth select wraps to SPEED
        m_field = 2'd0;
        press(1'b1, 1'b0, 20);
        check_all("sel_wrap");

        // Move to TAIL, then press both together
        m_field = 2'd1;
        press(1'b1, 1'b0, 20);
        check_all("sel_tail");
        m_tail  = 1'b1;
        m_field = 2'd2;
        push_exp();
        press(1'b1, 1'b1, 20);
        check_all("simultaneous");

        // Reset at filter count 4 of an inc press
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        check_all("reset_midfilter");

        // Button held through reset release counts as a fresh press
        @(negedge clk);
        reset   = 1'b1;
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        m_speed = 3'd1;
        push_exp();
        reset = 1'b0;
        repeat (20) @(negedge clk);
        btn_inc = 1'b0;
        repeat (16) @(negedge clk);
        check_all("held_through_reset");

        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chase_config_ctrl.md
CHASE_CONFIG_CTRL -- requirements
Module: chase_config_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_WIDTH, default 10: debounce counter width; filter length is 2^DEBOUNCE_WIDTH-1 cycles.
REQ-002 SHALL have parameter SPEED_RESET, default 3'd0: cfg_speed value after reset.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port btn_sel, input, 1: raw pushbutton, asynchronous to clk, active-high; selects the field to edit.
REQ-006 SHALL have port btn_inc, input, 1: raw pushbutton, asynchronous, active-high; edits the selected field.
REQ-007 SHALL have port cfg_speed, output, 3: chase speed prefix for the downstream chaser.
REQ-008 SHALL have port cfg_tail, output, 1: fade tail enable.
REQ-009 SHALL have port cfg_dir, output, 1: chase direction; 1 = forward.
REQ-010 SHALL have port cfg_invert, output, 1: LED polarity invert.
REQ-011 SHALL have port field, output, 2: currently selected field; 0 SPEED, 1 TAIL, 2 DIR, 3 INV.
REQ-012 SHALL have port cfg_changed, output, 1: one-cycle pulse, high in the cycle a cfg_* output takes a new value.

Function
REQ-013 SHALL pass each button through a two-flop synchronizer before any other logic.
REQ-014 SHALL keep, per button, a debounced level and a DEBOUNCE_WIDTH-bit counter; counter clears whenever synchronized level equals debounced level.
REQ-015 SHALL increment the counter each cycle synchronized differs from debounced; on an edge where counter is all-ones and the mismatch persists, debounced takes the synchronized value and counter clears.
REQ-016 SHALL produce a press event (combinational) in the cycle debounced rises 0->1; release produces no event.
REQ-017 SHALL reject any synchronized pulse shorter than 2^DEBOUNCE_WIDTH-1 cycles (no debounced change).
REQ-018 SHALL, on a raw level held steady, update the config/field registers on rising edge 2^DEBOUNCE_WIDTH+3, counted from the first edge that samples the new raw level.
REQ-019 SHALL implement FSM states SPEED->TAIL->DIR->INV->SPEED, advancing one state per sel press; INV wraps to SPEED; field encodes the state.
REQ-020 SHALL, on inc press in SPEED, set cfg_speed to cfg_speed+1 modulo 8 (7 wraps to 0).
REQ-021 SHALL, on inc press in TAIL/DIR/INV, invert cfg_tail/cfg_dir/cfg_invert respectively.
REQ-022 SHALL, on simultaneous sel and inc press events, apply inc to the current (old) field, then advance field in the same edge.
REQ-023 SHALL register cfg_changed so it is high exactly in the cycle following the edge that applied an inc; no pulse on sel-only presses.
REQ-024 SHALL keep all cfg_* and field outputs registered, glitch-free, and stable between presses.

Reset
REQ-025 SHALL on reset clear synchronizers, counters, debounced levels and cfg_changed to 0; field=SPEED; cfg_speed=SPEED_RESET; cfg_tail=0; cfg_dir=1; cfg_invert=0.
REQ-026 SHALL discard any in-progress debounce when reset asserts mid-filter; no press event is generated by that activity.
REQ-027 SHALL treat a button held through reset release as a fresh press after full filtering.

Structure
REQ-028 SHALL place the field encoding (SPEED/TAIL/DIR/INV constants) and default DEBOUNCE_WIDTH in shared package chase_pkg.
REQ-029 SHALL implement filtering in sub-module button_debounce (sync + counter + debounced level + rise pulse), instanced twice.
REQ-030 SHALL fit in 120-400 lines of RTL total.

Verification (bench with DEBOUNCE_WIDTH=3)
REQ-031 SHALL check reset: outputs = speed 0, tail 0, dir 1, invert 0, field 0, cfg_changed 0.
REQ-032 SHALL check clean inc press (raw high 20 cycles) -> cfg_speed 0->1 on edge 11, cfg_changed high one cycle; eight presses total -> speed wraps back to 0.
REQ-033 SHALL check bounce: btn_inc high 5 cycles then low -> no output change, no cfg_changed.
REQ-034 SHALL check sel x3 then inc -> field=3, cfg_invert=1; a 4th sel -> field=0.
REQ-035 SHALL check btn_sel and btn_inc rising same cycle in TAIL -> cfg_tail toggles, field becomes DIR, single cfg_changed pulse.
REQ-036 SHALL check reset asserted at filter count 4 of a press -> post-reset outputs at reset values, no cfg_changed.
